mole_hit_detector: RTL

Input-conditioning and hit-qualification stage for the whack-a-mole game, sitting directly upstream of the score counter. It synchronizes and debounces the five player switches, converts each debounced switch change into a "whack", and checks every whack against the current mole LED pattern. The output is a single-cycle `hit_pulse` per mole window that the score counter increments on, plus a `miss_pulse` for wrong whacks.

---
 rtl/whack_pkg.sv | 13 +
 rtl/switch_debounce.sv | 52 +++++
 rtl/mole_hit_detector.sv | 79 +++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole datapath.
// Used by the hit detector, the random LED stage and the score stage.
//   NUM_MOLES        - number of switch / LED positions
//   DB_TICKS_DEFAULT - stable 1 kHz samples needed to accept a switch change
//   mole_vec_t       - one bit per mole position
package whack_pkg;

    localparam int NUM_MOLES        = 5;
    localparam int DB_TICKS_DEFAULT = 10;

    typedef logic [NUM_MOLES-1:0] mole_vec_t;

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchronizer followed by a tick-sampled debouncer.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-low
//   tick_1khz - one-cycle sampling strobe
//   switch_in - raw asynchronous switch
//   sw_db     - debounced level
module switch_debounce
    import whack_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1khz,
    input  logic switch_in,
    output logic sw_db
);

    localparam int CNT_W = $clog2(DB_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            sw_db  <= 1'b0;
        end else begin
            sync_1 <= switch_in;
            sync_2 <= sync_1;
            if (tick_1khz) begin
                if (sync_2 != sw_db) begin
                    // The increment that would land on DB_TICKS accepts the new level.
                    if (cnt == CNT_LAST) begin
                        sw_db <= sync_2;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mole_hit_detector.sv
// Switch conditioning and hit qualification upstream of the score counter.
// Debounces each switch, turns every debounced change into a whack and
// judges it against the current mole pattern; at most one hit per window.
// Ports:
//   clk, reset  - system clock, synchronous active-low reset
//   tick_1khz   - debounce sampling strobe
//   switch_in   - raw switches
//   mole_mask   - lit moles (1 = lit)
//   game_active - play phase
//   sw_db       - debounced switch levels
//   hit_pulse   - one cycle per qualifying hit
//   miss_pulse  - one cycle per whack of an unlit position
//   locked      - a hit has already been scored in this mole window
module mole_hit_detector #(
    parameter int NUM_MOLES = whack_pkg::NUM_MOLES,
    parameter int DB_TICKS  = whack_pkg::DB_TICKS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_1khz,
    input  logic [NUM_MOLES-1:0] switch_in,
    input  logic [NUM_MOLES-1:0] mole_mask,
    input  logic                 game_active,
    output logic [NUM_MOLES-1:0] sw_db,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 locked
);

    logic [NUM_MOLES-1:0] sw_db_q;
    logic [NUM_MOLES-1:0] mask_q;
    logic [NUM_MOLES-1:0] whack;
    logic                 window_change;
    logic                 lock_eff;
    logic                 hit_now;
    logic                 miss_now;

    for (genvar g = 0; g < NUM_MOLES; g++) begin : g_db
        switch_debounce #(
            .DB_TICKS (DB_TICKS)
        ) u_db (
            .clk       (clk),
            .reset     (reset),
            .tick_1khz (tick_1khz),
            .switch_in (switch_in[g]),
            .sw_db     (sw_db[g])
        );
    end

    always_comb begin
        whack         = sw_db ^ sw_db_q;
        // An all-dark mask also counts as a new window so a stale lock never survives it.
        window_change = (mole_mask != mask_q) || (mole_mask == '0);
        lock_eff      = locked && !window_change;
        hit_now       = game_active && !lock_eff && |(whack & mole_mask);
        miss_now      = game_active && |(whack & ~mole_mask);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_db_q    <= '0;
            mask_q     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            locked     <= 1'b0;
        end else begin
            sw_db_q    <= sw_db;
            mask_q     <= mole_mask;
            hit_pulse  <= hit_now;
            miss_pulse <= miss_now;
            if (hit_now) begin
                locked <= 1'b1;
            end else if (window_change || !game_active) begin
                locked <= 1'b0;
            end
        end
    end

endmodule
